// File: rtl/modulator_pkg.sv
// Shared types and helpers for the DCSK modulator.
package modulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    INFO = 2'd2
  } state_t;

  // Counter width that never collapses to zero bits for depth-1 cases.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcsk_delay_line.sv
// DEPTH-deep shift register holding the reference chips of the current bit.
// dout is the oldest stored chip.
module dcsk_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  assign dout = sr[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage line: just a register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sr <= '0;
        else if (shift_en) sr <= din;
      end
    end else begin : g_multi
      // Shift toward the MSB so the oldest chip sits at the output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sr <= '0;
        else if (shift_en) sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

endmodule

// File: rtl/modulator.sv
// DCSK modulator: per message bit, DELAY reference chips taken from the
// chaotic source, followed by DELAY information chips that repeat (bit 1)
// or invert (bit 0) the reference chips. Message is sent MSB first.
//
// state | meaning
// IDLE  | output 0, waiting for send
// REF   | transmitting reference chips, filling the delay line
// INFO  | transmitting delayed reference chips modulated by the message bit
module modulator
  import modulator_pkg::*;
#(
  parameter int MSG_WIDTH = 4,
  parameter int DELAY     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 send,
  input  logic                 chaos_bit,
  input  logic [MSG_WIDTH-1:0] message,
  output logic                 modulated_bit
);

  localparam int CW = cnt_width(DELAY);
  localparam int BW = cnt_width(MSG_WIDTH);
  localparam logic [CW-1:0] CHIP_LAST = CW'(DELAY - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(MSG_WIDTH - 1);

  state_t               state, state_nxt;
  logic [MSG_WIDTH-1:0] msg_reg;
  logic [CW-1:0]        chip_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 chip_last, bit_last, cur_bit;
  logic                 line_en, line_din, line_dout;

  assign chip_last = (chip_cnt == CHIP_LAST);
  assign bit_last  = (bit_idx == BIT_LAST);
  assign line_en   = (state != IDLE);
  assign line_din  = (state == REF) ? chaos_bit : 1'b0;

  dcsk_delay_line #(.DEPTH(DELAY)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (line_en),
    .din      (line_din),
    .dout     (line_dout)
  );

  // Select the message bit being sent; bit index 0 maps to the MSB.
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < MSG_WIDTH; i++) begin
      if (BW'(MSG_WIDTH - 1 - i) == bit_idx) cur_bit = msg_reg[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; send is only looked at while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (send) state_nxt = REF;
      REF:     if (chip_last) state_nxt = INFO;
      INFO:    if (chip_last) state_nxt = bit_last ? IDLE : REF;
      default: state_nxt = IDLE;
    endcase
  end

  // Message latch, chip counter and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_reg  <= '0;
      chip_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (send) begin
            msg_reg  <= message;
            chip_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        REF: begin
          chip_cnt <= chip_last ? '0 : chip_cnt + 1'b1;
        end
        INFO: begin
          chip_cnt <= chip_last ? '0 : chip_cnt + 1'b1;
          if (chip_last) bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
        end
        default: begin
          chip_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  // Registered chip output; information chips XOR the stored reference
  // with the inverted message bit so a 1 repeats and a 0 inverts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modulated_bit <= 1'b0;
    end else begin
      case (state)
        REF:     modulated_bit <= chaos_bit;
        INFO:    modulated_bit <= line_dout ^ ~cur_bit;
        default: modulated_bit <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_modulator.sv
// Directed bench for the DCSK modulator: default build plus a
// DELAY=1 / MSG_WIDTH=1 build sharing the same clock.
module tb_modulator;

  logic       clk;
  logic       rst_n;
  logic       send, chaos_bit, modulated_bit;
  logic [3:0] message;
  logic       send1, chaos1, msg1, mod1;

  int n_checks = 0;
  int n_errors = 0;

  modulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .send          (send),
    .chaos_bit     (chaos_bit),
    .message       (message),
    .modulated_bit (modulated_bit)
  );

  modulator #(.MSG_WIDTH(1), .DELAY(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .send          (send1),
    .chaos_bit     (chaos1),
    .message       (msg1),
    .modulated_bit (mod1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One frame on the default build. message is flipped mid-frame; when
  // hold is set, send is raised mid-frame and kept high so a second frame
  // (latching the flipped word) follows after one idle cycle.
  task automatic run_frame(input string tag, input logic [3:0] msg,
                           input logic [15:0] chaos, input logic [15:0] exp_chips,
                           input bit hold, input logic [15:0] exp_next);
    logic [15:0] got;
    got = '0;
    @(negedge clk);
    send = 1'b1; message = msg; chaos_bit = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check({tag, "_accept"}, {15'b0, modulated_bit}, 16'h0);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) message = ~msg;
      if (hold && k == 5) send = 1'b1;
      chaos_bit = chaos[15-k];
      @(negedge clk);
      got[15-k] = modulated_bit;
    end
    check(tag, got, exp_chips);
    chaos_bit = 1'b1;
    @(negedge clk);
    check({tag, "_gap"}, {15'b0, modulated_bit}, 16'h0);
    if (hold) begin
      send = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        got[15-k] = modulated_bit;
      end
      check({tag, "_next"}, got, exp_next);
    end
    @(negedge clk);
    check({tag, "_idle"}, {15'b0, modulated_bit}, 16'h0);
  endtask

  // Two-chip frame on the DELAY=1 / MSG_WIDTH=1 build. The chaos input
  // during the information chip is the opposite of the reference chip.
  task automatic run_small(input string tag, input logic m, input logic c0,
                           input logic [1:0] exp2);
    logic [1:0] got;
    @(negedge clk);
    send1 = 1'b1; msg1 = m; chaos1 = ~c0;
    @(negedge clk);
    send1 = 1'b0; chaos1 = c0;
    @(negedge clk);
    got[1] = mod1;
    chaos1 = ~c0;
    @(negedge clk);
    got[0] = mod1;
    check(tag, {14'b0, got}, {14'b0, exp2});
    @(negedge clk);
    check({tag, "_idle"}, {15'b0, mod1}, 16'h0);
  endtask

  initial begin
    logic acc;
    rst_n = 1'b0; send = 1'b0; chaos_bit = 1'b0; message = '0;
    send1 = 1'b0; chaos1 = 1'b0; msg1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {15'b0, modulated_bit}, 16'h0);
    check("reset_out1", {15'b0, mod1}, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("ones_1011", 4'b1011, 16'hFFFF, 16'hFCFF, 1'b0, 16'h0);
    run_frame("alt_0000",  4'b0000, 16'hAAAA, 16'h9999, 1'b0, 16'h0);
    run_frame("alt_1011",  4'b1011, 16'hAAAA, 16'hA9AA, 1'b0, 16'h0);
    run_frame("mix_0110",  4'b0110, 16'hC35E, 16'hC05C, 1'b0, 16'h0);
    run_frame("hold_send", 4'b1011, 16'hFFFF, 16'hFCFF, 1'b1, 16'hCFCC);

    // Reset pulse in the middle of an information phase.
    @(negedge clk);
    send = 1'b1; message = 4'b1011; chaos_bit = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_info", {15'b0, modulated_bit}, 16'h1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {15'b0, modulated_bit}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    acc = 1'b0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | modulated_bit;
    end
    check("post_reset_quiet", {15'b0, acc}, 16'h0);
    run_frame("after_reset", 4'b1101, 16'hFFFF, 16'hFFCF, 1'b0, 16'h0);

    run_small("d1_m1_c1", 1'b1, 1'b1, 2'b11);
    run_small("d1_m0_c1", 1'b0, 1'b1, 2'b10);
    run_small("d1_m0_c0", 1'b0, 1'b0, 2'b01);
    run_small("d1_m1_c0", 1'b1, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
